// File: rtl/mha_head_scheduler_pkg.sv
// Package mha_sched_pkg: shared sizing, FSM state encoding and head-pick helper
// for the multi-head attention scheduler.
//   NUM_HEADS / NUM_ROWS / DATA_W : tile geometry (heads, rows per tile, row width)
//   HEAD_W / ROW_W                : counter widths, at least 1 bit each
//   state_t                       : scheduler FSM states
//   next_head(mask, cur)          : lowest set mask bit strictly above cur
package mha_sched_pkg;

  localparam int NUM_HEADS = 4;
  localparam int NUM_ROWS  = 4;
  localparam int DATA_W    = 256;
  localparam int HEAD_W    = (NUM_HEADS > 1) ? $clog2(NUM_HEADS) : 1;
  localparam int ROW_W     = (NUM_ROWS  > 1) ? $clog2(NUM_ROWS)  : 1;

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_SELECT,
    ST_START,
    ST_STREAM,
    ST_WAIT_DONE,
    ST_FINISH
  } state_t;

  typedef struct packed {
    logic              found;
    logic [HEAD_W-1:0] idx;
  } head_pick_t;

  // cur is one bit wider than a head index and signed so that -1 means
  // "nothing served yet" and every head index compares above it.
  function automatic head_pick_t next_head(input logic [NUM_HEADS-1:0] mask,
                                           input logic signed [HEAD_W:0] cur);
    head_pick_t p;
    p = '0;
    // Walk downwards so the last hit is the lowest qualifying index.
    for (int i = NUM_HEADS - 1; i >= 0; i--) begin
      if (mask[i] && (i > int'(cur))) begin
        p.found = 1'b1;
        p.idx   = HEAD_W'(i);
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/mha_head_scheduler_buffer.sv
// head_tile_buffer: per-head Q/K tile store.
//   clk, rst_n      : clock, async active-low reset (read register only)
//   wr_en, wr_row   : broadside write of every head at one row index
//   wr_q, wr_k      : one Q and one K row per head
//   rd_head, rd_row : read address, sampled every clock
//   rd_q, rd_k      : registered read data (one cycle after address)
module head_tile_buffer #(
  parameter int NUM_HEADS = 4,
  parameter int NUM_ROWS  = 4,
  parameter int DATA_W    = 256,
  parameter int HEAD_W    = 2,
  parameter int ROW_W     = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              wr_en,
  input  logic [ROW_W-1:0]                  wr_row,
  input  logic [NUM_HEADS-1:0][DATA_W-1:0]  wr_q,
  input  logic [NUM_HEADS-1:0][DATA_W-1:0]  wr_k,
  input  logic [HEAD_W-1:0]                 rd_head,
  input  logic [ROW_W-1:0]                  rd_row,
  output logic [DATA_W-1:0]                 rd_q,
  output logic [DATA_W-1:0]                 rd_k
);

  logic [NUM_HEADS-1:0][2*DATA_W-1:0] head_rd;
  logic [2*DATA_W-1:0]                rd_data;

  // One storage lane per head; contents need no reset.
  for (genvar h = 0; h < NUM_HEADS; h++) begin : g_head
    logic [NUM_ROWS-1:0][2*DATA_W-1:0] rows;

    always_ff @(posedge clk) begin
      if (wr_en) rows[wr_row] <= {wr_q[h], wr_k[h]};
    end

    assign head_rd[h] = rows[rd_row];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data <= '0;
    else        rd_data <= head_rd[rd_head];
  end

  assign rd_q = rd_data[2*DATA_W-1:DATA_W];
  assign rd_k = rd_data[DATA_W-1:0];

endmodule

// File: rtl/mha_head_scheduler.sv
// mha_head_scheduler: time-multiplexes one attention head engine over NUM_HEADS
// heads. Captures a full Q/K tile set from the projection stage, then for each
// head in the latched mask pulses eng_start, streams the head's rows with
// valid/ready and waits for eng_done.
//   in_valid/in_ready/in_q/in_k : projection rows, all heads per beat
//   head_mask                   : heads to run, latched with the last row
//   eng_start/eng_head          : start pulse and index of head being served
//   eng_valid/eng_ready/eng_q/eng_k/eng_last : row stream to the engine
//   eng_done                    : engine finished current head
//   done/busy                   : set complete pulse, not-in-LOAD status
//   err_ovf/err_proto           : sticky overflow / unexpected-done flags
module mha_head_scheduler
  import mha_sched_pkg::*;
(
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [NUM_HEADS-1:0][DATA_W-1:0]  in_q,
  input  logic [NUM_HEADS-1:0][DATA_W-1:0]  in_k,
  input  logic [NUM_HEADS-1:0]              head_mask,
  output logic                              eng_start,
  output logic [HEAD_W-1:0]                 eng_head,
  output logic                              eng_valid,
  input  logic                              eng_ready,
  output logic [DATA_W-1:0]                 eng_q,
  output logic [DATA_W-1:0]                 eng_k,
  output logic                              eng_last,
  input  logic                              eng_done,
  output logic                              done,
  output logic                              busy,
  output logic                              err_ovf,
  output logic                              err_proto
);

  state_t                   state, state_nx;
  logic [ROW_W-1:0]         row;
  logic signed [HEAD_W:0]   cur;
  logic [NUM_HEADS-1:0]     mask_q;
  head_pick_t               pick;
  logic                     load_fire, eng_fire, row_last;
  logic [ROW_W-1:0]         rd_row;

  assign row_last  = (row == ROW_W'(NUM_ROWS - 1));
  assign load_fire = in_valid && (state == ST_LOAD);
  assign eng_fire  = (state == ST_STREAM) && eng_ready;
  assign pick      = next_head(mask_q, cur);
  assign eng_head  = cur[HEAD_W-1:0];

  // Read address runs one row ahead on a handshake so the registered read
  // port presents the next row right after the accepting edge; without a
  // handshake the address (and thus the data) holds.
  assign rd_row = eng_fire ? (row_last ? '0 : row + ROW_W'(1)) : row;

  head_tile_buffer #(
    .NUM_HEADS (NUM_HEADS),
    .NUM_ROWS  (NUM_ROWS),
    .DATA_W    (DATA_W),
    .HEAD_W    (HEAD_W),
    .ROW_W     (ROW_W)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (load_fire),
    .wr_row  (row),
    .wr_q    (in_q),
    .wr_k    (in_k),
    .rd_head (cur[HEAD_W-1:0]),
    .rd_row  (rd_row),
    .rd_q    (eng_q),
    .rd_k    (eng_k)
  );

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    busy      = 1'b1;
    eng_start = 1'b0;
    eng_valid = 1'b0;
    eng_last  = 1'b0;
    done      = 1'b0;
    case (state)
      ST_LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (load_fire && row_last) state_nx = ST_SELECT;
      end
      ST_SELECT:    state_nx = pick.found ? ST_START : ST_FINISH;
      ST_START: begin
        eng_start = 1'b1;
        state_nx  = ST_STREAM;
      end
      ST_STREAM: begin
        eng_valid = 1'b1;
        eng_last  = row_last;
        if (eng_fire && row_last) state_nx = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: if (eng_done) state_nx = ST_SELECT;
      ST_FINISH: begin
        done     = 1'b1;
        state_nx = ST_LOAD;
      end
      default:      state_nx = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_LOAD;
      row       <= '0;
      cur       <= '0;
      mask_q    <= '0;
      err_ovf   <= 1'b0;
      err_proto <= 1'b0;
    end else begin
      state <= state_nx;
      // One row counter serves both the load and the stream phases.
      if (load_fire || eng_fire) row <= row_last ? '0 : row + ROW_W'(1);
      if (load_fire && row_last) begin
        mask_q <= head_mask;
        cur    <= '1;  // -1: no head served yet
      end
      if ((state == ST_SELECT) && pick.found) cur <= {1'b0, pick.idx};
      if (in_valid && (state != ST_LOAD))      err_ovf   <= 1'b1;
      if (eng_done && (state != ST_WAIT_DONE)) err_proto <= 1'b1;
    end
  end

endmodule
